// File: rtl/psola_playback_pkg.sv
// Shared constants and types for the PSOLA playback reader.
// Buffer geometry, BRAM latency, FSM states and the read tag.
package psola_pkg;

    localparam int MAX_EXTENDED  = 2200;
    localparam int FRACTION_BITS = 11;
    localparam int READ_LATENCY  = 2;
    localparam int ADDR_BITS     = $clog2(MAX_EXTENDED);
    localparam int LEN_BITS      = 12;

    typedef enum logic {
        IDLE,
        PLAY
    } playback_state_t;

    typedef struct packed {
        logic                 vld;
        logic [ADDR_BITS-1:0] addr;
        logic                 last;
    } rd_tag_t;

    // Drop the fraction; clamp when any bit above the 16-bit sample is set.
    function automatic logic [15:0] word_to_sample(
        input logic [31:0] w
    );
        logic [31-FRACTION_BITS-16:0] hi;
        hi = w[31:FRACTION_BITS+16];
        if (|hi) begin
            return 16'hFFFF;
        end
        return w[FRACTION_BITS+15:FRACTION_BITS];
    endfunction

endpackage

// File: rtl/psola_playback_if.sv
// BRAM port bundle between the playback reader and the PSOLA buffer.
// Read address/data plus the zeroing write port.
interface psola_playback_if;
    import psola_pkg::*;

    logic [ADDR_BITS-1:0] read_addr;
    logic [31:0]          read_val;
    logic [ADDR_BITS-1:0] clear_addr;
    logic                 clear_en;

    modport master (
        output read_addr,
        output clear_addr,
        output clear_en,
        input  read_val
    );

    modport slave (
        input  read_addr,
        input  clear_addr,
        input  clear_en,
        output read_val
    );

endinterface

// File: rtl/psola_playback_pipe.sv
// Delay line that tracks an issued BRAM read until its data returns.
// busy_o is high while any issued read has not yet come back.
module psola_playback_pipe
    import psola_pkg::*;
#(
    parameter int STAGES = READ_LATENCY
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o,
    output logic    busy_o
);

    rd_tag_t stage_q [STAGES];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[STAGES-1];

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            busy_o = busy_o | stage_q[i].vld;
        end
    end

endmodule

// File: rtl/psola_playback.sv
// Streams one overlap-added window out of the PSOLA buffer per
// sample tick, zeroing each word as it is consumed.
module psola_playback
    import psola_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [LEN_BITS-1:0] window_len_in,
    input  logic                window_len_valid_in,
    input  logic                sample_tick_in,
    psola_playback_if.master    bram,
    output logic [15:0]         sample_out,
    output logic                sample_valid_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                underrun_out,
    output logic                tick_drop_out
);

    playback_state_t      state_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic [LEN_BITS-1:0]  len_q;
    logic [LEN_BITS-1:0]  pend_q;
    logic                 pend_vld_q;
    logic [15:0]          sample_q;
    logic                 sample_vld_q;
    logic                 done_q;
    logic                 under_q;
    logic                 drop_q;
    logic                 clr_en_q;
    logic [ADDR_BITS-1:0] clr_addr_q;

    logic [LEN_BITS-1:0]  cap_d;
    logic                 len_ok_d;
    logic                 last_d;
    logic                 block_d;
    logic                 issue_d;
    logic [15:0]          sat_d;
    logic                 pipe_busy;
    rd_tag_t              tag_in;
    rd_tag_t              tag_ret;

    localparam logic [LEN_BITS-1:0] MAX_LEN =
        LEN_BITS'(MAX_EXTENDED);

    assign cap_d = (window_len_in > MAX_LEN) ? MAX_LEN
                                             : window_len_in;
    assign len_ok_d = window_len_valid_in
                    && (window_len_in != '0);
    assign last_d = (LEN_BITS'(idx_q)
                     == (len_q - LEN_BITS'(1)));

    // The done cycle also blocks ticks while the next window is chosen.
    assign block_d = pipe_busy | done_q;
    assign issue_d = (state_q == PLAY) && sample_tick_in
                   && !block_d;
    assign sat_d   = word_to_sample(bram.read_val);

    assign tag_in = '{vld: issue_d, addr: idx_q, last: last_d};

    psola_playback_pipe #(
        .STAGES (READ_LATENCY)
    ) u_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .tag_i  (tag_in),
        .tag_o  (tag_ret),
        .busy_o (pipe_busy)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            done_q       <= 1'b0;
            under_q      <= 1'b0;
            drop_q       <= 1'b0;
            clr_en_q     <= 1'b0;
            clr_addr_q   <= '0;
        end else begin
            sample_vld_q <= 1'b0;
            done_q       <= 1'b0;
            under_q      <= 1'b0;
            drop_q       <= 1'b0;
            clr_en_q     <= 1'b0;
            if (tag_ret.vld) begin
                sample_q     <= sat_d;
                sample_vld_q <= 1'b1;
                clr_en_q     <= 1'b1;
                clr_addr_q   <= tag_ret.addr;
                done_q       <= tag_ret.last;
            end
            unique case (state_q)
                IDLE: begin
                    if (sample_tick_in) begin
                        sample_q     <= '0;
                        sample_vld_q <= 1'b1;
                        under_q      <= 1'b1;
                    end
                    if (len_ok_d) begin
                        len_q   <= cap_d;
                        idx_q   <= '0;
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (done_q) begin
                        if (len_ok_d) begin
                            len_q      <= cap_d;
                            idx_q      <= '0;
                            pend_vld_q <= 1'b0;
                        end else if (pend_vld_q) begin
                            len_q      <= pend_q;
                            idx_q      <= '0;
                            pend_vld_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (len_ok_d) begin
                        pend_q     <= cap_d;
                        pend_vld_q <= 1'b1;
                    end
                    if (sample_tick_in && block_d) begin
                        drop_q <= 1'b1;
                    end
                    if (issue_d && !last_d) begin
                        idx_q <= idx_q + ADDR_BITS'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bram.read_addr  = idx_q;
    assign bram.clear_addr = clr_addr_q;
    assign bram.clear_en   = clr_en_q;

    assign sample_out       = sample_q;
    assign sample_valid_out = sample_vld_q;
    assign busy_out         = (state_q == PLAY);
    assign done_out         = done_q;
    assign underrun_out     = under_q;
    assign tick_drop_out    = drop_q;

endmodule

// File: tb/tb_psola_playback.sv
// Bench for psola_playback: BRAM model plus an event-level
// reference of window playback, driven by directed and random ticks.
module tb_psola_playback;
    import psola_pkg::*;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic [LEN_BITS-1:0] window_len_in;
    logic                window_len_valid_in;
    logic                sample_tick_in;
    logic [15:0]         sample_out;
    logic                sample_valid_out;
    logic                busy_out;
    logic                done_out;
    logic                underrun_out;
    logic                tick_drop_out;
    logic                load;

    psola_playback_if bus ();

    psola_playback dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .window_len_in       (window_len_in),
        .window_len_valid_in (window_len_valid_in),
        .sample_tick_in      (sample_tick_in),
        .bram                (bus),
        .sample_out          (sample_out),
        .sample_valid_out    (sample_valid_out),
        .busy_out            (busy_out),
        .done_out            (done_out),
        .underrun_out        (underrun_out),
        .tick_drop_out       (tick_drop_out)
    );

    always #5 clk_in = ~clk_in;

    logic [31:0] mem     [MAX_EXTENDED];
    logic [31:0] img     [MAX_EXTENDED];
    logic [31:0] ref_mem [MAX_EXTENDED];
    logic [31:0] rd1, rd2;

    always @(posedge clk_in) begin
        if (load) begin
            for (int k = 0; k < MAX_EXTENDED; k++) begin
                mem[k] <= img[k];
            end
        end else if (bus.clear_en) begin
            mem[bus.clear_addr] <= '0;
        end
        rd1 <= (int'(bus.read_addr) < MAX_EXTENDED)
             ? mem[bus.read_addr] : 32'h0;
        rd2 <= rd1;
    end
    assign bus.read_val = rd2;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model state: what a listener of the buffer would track.
    bit          m_play;
    int          m_len, m_word, m_pend;
    int          m_block, m_done_at;
    int          ev_at, ev_addr;
    bit          ev_last;
    logic [15:0] ev_smp;
    bit          e_valid, e_done, e_under, e_drop, e_clr, e_busy;
    logic [15:0] e_smp;
    int          e_clr_addr, e_raddr;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_play = 0; m_len = 0; m_word = 0; m_pend = -1;
        m_block = -1; m_done_at = -1; ev_at = -1;
        e_valid = 0; e_done = 0; e_under = 0; e_drop = 0;
        e_clr = 0; e_busy = 0; e_smp = '0;
        e_clr_addr = 0; e_raddr = 0;
    endtask

    task automatic model_step(input bit r, input int wl,
                              input bit v, input bit t);
        int          cap, a;
        bit          nplay, last;
        longint      frac;
        e_valid = 0; e_done = 0; e_under = 0;
        e_drop = 0; e_clr = 0;
        if (r) begin
            model_reset();
            return;
        end
        nplay = m_play;
        if (ev_at == cyc + 1) begin
            e_valid = 1; e_smp = ev_smp; e_clr = 1;
            e_clr_addr = ev_addr; e_done = ev_last;
            ref_mem[ev_addr] = '0;
            ev_at = -1;
        end
        cap = (wl > MAX_EXTENDED) ? MAX_EXTENDED : wl;
        if (!m_play) begin
            if (t) begin
                e_valid = 1; e_smp = '0; e_under = 1;
            end
            if (v && cap != 0) begin
                nplay = 1; m_len = cap; m_word = 0;
            end
        end else begin
            if (cyc == m_done_at) begin
                if (v && cap != 0) begin
                    m_len = cap; m_word = 0; m_pend = -1;
                end else if (m_pend > 0) begin
                    m_len = m_pend; m_word = 0; m_pend = -1;
                end else begin
                    nplay = 0;
                end
            end else if (v && cap != 0) begin
                m_pend = cap;
            end
            if (t) begin
                if (cyc <= m_block) begin
                    e_drop = 1;
                end else begin
                    a = m_word;
                    last = (a == m_len - 1);
                    frac = longint'(ref_mem[a]) >> FRACTION_BITS;
                    ev_smp = (frac > 65535) ? 16'hFFFF
                                            : 16'(frac);
                    ev_at = cyc + 3; ev_addr = a; ev_last = last;
                    if (last) begin
                        m_done_at = cyc + 3; m_block = cyc + 3;
                    end else begin
                        m_block = cyc + 2; m_word++;
                    end
                end
            end
        end
        m_play = nplay;
        e_busy = nplay;
        e_raddr = m_word;
    endtask

    task automatic compare();
        check("valid", 32'(sample_valid_out), 32'(e_valid));
        check("sample", 32'(sample_out), 32'(e_smp));
        check("done", 32'(done_out), 32'(e_done));
        check("underrun", 32'(underrun_out), 32'(e_under));
        check("tick_drop", 32'(tick_drop_out), 32'(e_drop));
        check("clear_en", 32'(bus.clear_en), 32'(e_clr));
        check("busy", 32'(busy_out), 32'(e_busy));
        check("read_addr", 32'(bus.read_addr), 32'(e_raddr));
        if (e_clr) begin
            check("clear_addr", 32'(bus.clear_addr),
                  32'(e_clr_addr));
        end
    endtask

    task automatic step(input bit r, input int wl,
                        input bit v, input bit t);
        rst_in = r;
        window_len_in = wl[LEN_BITS-1:0];
        window_len_valid_in = v;
        sample_tick_in = t;
        model_step(r, wl, v, t);
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
        compare();
    endtask

    task automatic fill_img(input bit rnd, input bit special);
        for (int k = 0; k < MAX_EXTENDED; k++) begin
            img[k] = 32'(k) << FRACTION_BITS;
            if (rnd && $urandom_range(0, 3) == 0) begin
                img[k] = $urandom;
            end
        end
        if (special) begin
            img[1] = 32'hFFFF_FFFF;
            img[2] = 32'h0000_0C00;
        end
    endtask

    task automatic restart(input bit rnd, input bit special);
        step(1'b1, 0, 1'b0, 1'b0);
        fill_img(rnd, special);
        for (int k = 0; k < MAX_EXTENDED; k++) begin
            ref_mem[k] = img[k];
        end
        load = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0);
        load = 1'b0;
    endtask

    task automatic ticks(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 0, 1'b0, (i % period) == 0);
        end
    endtask

    initial begin
        load = 1'b0;
        model_reset();
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 1'b0);
        restart(1'b0, 1'b0);

        // Underrun with no window loaded.
        ticks(3, 2);

        // Four-word window, widely spaced ticks.
        step(1'b0, 4, 1'b1, 1'b0);
        ticks(45, 10);

        // Saturating and small fixed-point words.
        restart(1'b0, 1'b1);
        step(1'b0, 3, 1'b1, 1'b0);
        ticks(20, 5);

        // Back-to-back ticks: the second is dropped.
        restart(1'b0, 1'b0);
        step(1'b0, 1, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        ticks(6, 100);

        // Pending window queued behind a playing one.
        restart(1'b0, 1'b0);
        step(1'b0, 3, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        ticks(4, 100);
        step(1'b0, 2, 1'b1, 1'b0);
        ticks(30, 5);

        // Reset in mid-window, then an underrun.
        restart(1'b0, 1'b0);
        step(1'b0, 5, 1'b1, 1'b0);
        ticks(8, 5);
        step(1'b1, 0, 1'b0, 1'b0);
        ticks(3, 2);

        // Oversized length clamps to the full buffer.
        restart(1'b0, 1'b0);
        step(1'b0, 4095, 1'b1, 1'b0);
        ticks(MAX_EXTENDED * 4 + 20, 4);

        // Random traffic against the reference.
        for (int b = 0; b < 6; b++) begin
            restart(1'b1, 1'b0);
            for (int i = 0; i < 600; i++) begin
                int wl;
                wl = ($urandom_range(0, 9) == 0) ? 0
                   : int'($urandom_range(1, 6));
                step($urandom_range(0, 799) == 0, wl,
                     $urandom_range(0, 29) == 0,
                     $urandom_range(0, 2) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
